// File: rtl/eth_tx_arb.sv
// Packet-level round-robin arbiter in front of the Ethernet MAC TX AXI-Stream port,
// with a stall watchdog. Define ETH_TX_ARB_PRIO_EN to give port 0 strict priority.
module eth_tx_arb #(
    parameter int NUM_PORTS     = 4,
    parameter int DWIDTH        = 512,
    parameter int KEEP_WIDTH    = DWIDTH / 8,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                             eth_clk,
    input  logic                             eth_rst_n,
    input  logic                             i_eth_rdy,
    input  logic [NUM_PORTS-1:0]             i_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             i_axis_tlast,
    input  logic [NUM_PORTS-1:0]             i_axis_tuser,
    input  logic [NUM_PORTS*DWIDTH-1:0]      i_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  i_axis_tkeep,
    output logic [NUM_PORTS-1:0]             o_axis_tready,
    output logic                             o_eth_axis_tx_tvalid,
    output logic                             o_eth_axis_tx_tlast,
    output logic                             o_eth_axis_tx_tuser,
    output logic [DWIDTH-1:0]                o_eth_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]            o_eth_axis_tx_tkeep,
    input  logic                             i_eth_axis_tx_tready,
    output logic [NUM_PORTS-1:0]             o_grant,
    output logic [15:0]                      o_abort_cnt
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int WW = $clog2(STALL_TIMEOUT);
    localparam logic [WW-1:0] WD_LIMIT = WW'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, ABORT, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [GW-1:0]        gidx_q, gidx_d;
    logic [GW-1:0]        last_q, last_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic [15:0]          abort_q, abort_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [GW-1:0]        cand;
    int                   sum;

    logic                  g_valid, g_last, g_user;
    logic [DWIDTH-1:0]     g_data;
    logic [KEEP_WIDTH-1:0] g_keep;

    assign g_valid = i_axis_tvalid[gidx_q];
    assign g_last  = i_axis_tlast[gidx_q];
    assign g_user  = i_axis_tuser[gidx_q];
    assign g_data  = i_axis_tdata[int'(gidx_q)*DWIDTH +: DWIDTH];
    assign g_keep  = i_axis_tkeep[int'(gidx_q)*KEEP_WIDTH +: KEEP_WIDTH];

    assign o_grant     = grant_q;
    assign o_abort_cnt = abort_q;

    // Search upward from the port after the last one served.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        sum        = 0;
`ifdef ETH_TX_ARB_PRIO_EN
        if (i_axis_tvalid[0]) pick_found = 1'b1;
`endif
        for (int i = 1; i <= NUM_PORTS; i++) begin
            sum = int'(last_q) + i;
            if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
            cand = GW'(sum);
            if (!pick_found && i_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wd_d    = wd_q;
        abort_d = abort_q;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (i_eth_rdy && pick_found) begin
                    state_d = XFER;
                    gidx_d  = pick_idx;
                    grant_d = NUM_PORTS'(1) << pick_idx;
                end
            end
            XFER: begin
                // A completing tlast beat has valid=1, so it always wins over expiry.
                if (g_valid) begin
                    wd_d = '0;
                    if (i_eth_axis_tx_tready && g_last) begin
                        state_d = IDLE;
                        last_d  = gidx_q;
                        grant_d = '0;
                    end
                end else begin
                    wd_d = wd_q + WW'(1);
                    if (wd_d == WD_LIMIT) state_d = ABORT;
                end
            end
            ABORT: begin
                wd_d = '0;
                if (i_eth_axis_tx_tready) begin
                    state_d = DRAIN;
                    if (abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
                end
            end
            DRAIN: begin
                if (g_valid && g_last) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_eth_axis_tx_tvalid = 1'b0;
        o_eth_axis_tx_tlast  = 1'b0;
        o_eth_axis_tx_tuser  = 1'b0;
        o_eth_axis_tx_tdata  = '0;
        o_eth_axis_tx_tkeep  = '0;
        o_axis_tready        = '0;
        unique case (state_q)
            XFER: begin
                o_eth_axis_tx_tvalid = g_valid;
                o_eth_axis_tx_tlast  = g_last;
                o_eth_axis_tx_tuser  = g_user;
                o_eth_axis_tx_tdata  = g_data;
                o_eth_axis_tx_tkeep  = g_keep;
                o_axis_tready        = grant_q & {NUM_PORTS{i_eth_axis_tx_tready}};
            end
            ABORT: begin
                o_eth_axis_tx_tvalid = 1'b1;
                o_eth_axis_tx_tlast  = 1'b1;
                o_eth_axis_tx_tuser  = 1'b1;
                o_eth_axis_tx_tkeep  = '1;
            end
            DRAIN:   o_axis_tready = grant_q;
            default: ;
        endcase
    end

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= GW'(NUM_PORTS - 1);
            wd_q    <= '0;
            abort_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: per-port source queues drive the requesters,
// expected MAC beats are queued at stimulus time and popped by a monitor.
module tb_eth_tx_arb;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int ST = 1024;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [KW-1:0] keep;
        int            gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic [KW-1:0] keep;
        int            cyc;
    } exp_t;

    logic             eth_clk = 1'b0;
    logic             eth_rst_n;
    logic             eth_rdy;
    logic [NP-1:0]    axis_tvalid, axis_tlast, axis_tuser;
    logic [NP*DW-1:0] axis_tdata;
    logic [NP*KW-1:0] axis_tkeep;
    logic [NP-1:0]    o_axis_tready;
    logic             o_eth_axis_tx_tvalid, o_eth_axis_tx_tlast, o_eth_axis_tx_tuser;
    logic [DW-1:0]    o_eth_axis_tx_tdata;
    logic [KW-1:0]    o_eth_axis_tx_tkeep;
    logic             mac_tready;
    logic [NP-1:0]    o_grant;
    logic [15:0]      o_abort_cnt;

    beat_t src_q [NP][$];
    exp_t  exp_q [$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;

    eth_tx_arb #(.NUM_PORTS(NP), .DWIDTH(DW), .KEEP_WIDTH(KW), .STALL_TIMEOUT(ST)) dut (
        .eth_clk              (eth_clk),
        .eth_rst_n            (eth_rst_n),
        .i_eth_rdy            (eth_rdy),
        .i_axis_tvalid        (axis_tvalid),
        .i_axis_tlast         (axis_tlast),
        .i_axis_tuser         (axis_tuser),
        .i_axis_tdata         (axis_tdata),
        .i_axis_tkeep         (axis_tkeep),
        .o_axis_tready        (o_axis_tready),
        .o_eth_axis_tx_tvalid (o_eth_axis_tx_tvalid),
        .o_eth_axis_tx_tlast  (o_eth_axis_tx_tlast),
        .o_eth_axis_tx_tuser  (o_eth_axis_tx_tuser),
        .o_eth_axis_tx_tdata  (o_eth_axis_tx_tdata),
        .o_eth_axis_tx_tkeep  (o_eth_axis_tx_tkeep),
        .i_eth_axis_tx_tready (mac_tready),
        .o_grant              (o_grant),
        .o_abort_cnt          (o_abort_cnt)
    );

    always #5 eth_clk = ~eth_clk;
    always @(posedge eth_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int p, input int k, input int b);
        return DW'(32'hC000_0000 | (p << 16) | (k << 8) | b);
    endfunction

    // Beat 1 of a packet may be preceded by gap1 idle-source cycles.
    task automatic push_src(input int p, input int k, input int n, input int gap1);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = mk(p, k, i);
            b.last = (i == n - 1);
            b.user = (p == 3 && i == 1);
            b.keep = (i == n - 1) ? 4'h3 : 4'hF;
            b.gap  = (i == 1) ? gap1 : 0;
            src_q[p].push_back(b);
        end
    endtask

    task automatic push_exp(input int p, input int k, input int n, input int ne, input int c1);
        exp_t e;
        for (int i = 0; i < ne; i++) begin
            e.data = mk(p, k, i);
            e.last = (i == n - 1);
            e.user = (p == 3 && i == 1);
            e.keep = (i == n - 1) ? 4'h3 : 4'hF;
            e.cyc  = (c1 < 0) ? -1 : c1 + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_synth(input int c1);
        exp_t e;
        e.data = '0;
        e.last = 1'b1;
        e.user = 1'b1;
        e.keep = '1;
        e.cyc  = c1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge eth_clk);
            #1;
            n++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic tick();
        @(posedge eth_clk);
        #2;
    endtask

    // Source engine: handshakes seen at negedge are retired just after the next posedge.
    initial begin
        logic [NP-1:0] hs;
        beat_t         b;
        axis_tvalid = '0;
        axis_tlast  = '0;
        axis_tuser  = '0;
        axis_tdata  = '0;
        axis_tkeep  = '0;
        forever begin
            @(negedge eth_clk);
            hs = axis_tvalid & o_axis_tready;
            @(posedge eth_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                axis_tvalid[p]           = 1'b0;
                axis_tlast[p]            = 1'b0;
                axis_tuser[p]            = 1'b0;
                axis_tdata[p*DW +: DW]   = '0;
                axis_tkeep[p*KW +: KW]   = '0;
                if (src_q[p].size() > 0) begin
                    b = src_q[p][0];
                    if (b.gap > 0) begin
                        b.gap = b.gap - 1;
                        src_q[p][0] = b;
                    end else begin
                        axis_tvalid[p]         = 1'b1;
                        axis_tlast[p]          = b.last;
                        axis_tuser[p]          = b.user;
                        axis_tdata[p*DW +: DW] = b.data;
                        axis_tkeep[p*KW +: KW] = b.keep;
                    end
                end
            end
        end
    end

    // Monitor: every MAC handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge eth_clk);
            if (eth_rst_n && o_eth_axis_tx_tvalid && mac_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mac_beat: unexpected beat data=0x%0h last=%0b user=%0b, want no beat",
                             o_eth_axis_tx_tdata, o_eth_axis_tx_tlast, o_eth_axis_tx_tuser);
                end else begin
                    e = exp_q.pop_front();
                    check("mac_beat",
                          64'({o_eth_axis_tx_tlast, o_eth_axis_tx_tuser, o_eth_axis_tx_tkeep, o_eth_axis_tx_tdata}),
                          64'({e.last, e.user, e.keep, e.data}));
                    if (e.cyc >= 0) check("mac_beat_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run did not complete, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int ord1 [5];
        int ord6p [4];
        int ord6k [4];
        int kcnt [NP];
        logic [NP-1:0] expg;

`ifdef ETH_TX_ARB_PRIO_EN
        ord1  = '{0, 0, 1, 2, 3};
        ord6p = '{0, 0, 1, 1};
        ord6k = '{8, 9, 8, 9};
`else
        ord1  = '{0, 1, 2, 3, 0};
        ord6p = '{0, 1, 0, 1};
        ord6k = '{8, 8, 9, 9};
`endif
        eth_rst_n  = 1'b0;
        eth_rdy    = 1'b1;
        mac_tready = 1'b1;
        repeat (3) @(posedge eth_clk);
        #2;
        check("reset_outputs",
              64'({o_eth_axis_tx_tvalid, o_eth_axis_tx_tlast, o_eth_axis_tx_tuser, |o_eth_axis_tx_tdata,
                   |o_eth_axis_tx_tkeep, o_axis_tready, o_grant, o_abort_cnt}), 64'd0);
        eth_rst_n = 1'b1;
        @(negedge eth_clk);
        check("idle_grant", 64'(o_grant), 64'd0);

        // Round-robin across four ports with 3-beat packets.
        tick();
        c0 = cyc;
        for (int p = 0; p < NP; p++) begin
            push_src(p, 0, 3, 0);
            kcnt[p] = 0;
        end
        push_src(0, 1, 3, 0);
        for (int i = 0; i < 5; i++) begin
            push_exp(ord1[i], kcnt[ord1[i]], 3, 3, c0 + 2 + 4 * i);
            kcnt[ord1[i]]++;
        end
        @(negedge eth_clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge eth_clk);
            expg = (c % 4 == 0) ? '0 : NP'(1) << ord1[c / 4];
            check("rr_grant_trace", 64'(o_grant), 64'(expg));
        end
        wait_drain("rr", 50);

        // Stall watchdog on port 2.
        tick();
        c0 = cyc;
        push_src(2, 0, 4, ST);
        push_exp(2, 0, 4, 1, c0 + 2);
        push_synth(c0 + 2 + ST);
        wait_drain("stall", ST + 100);
        repeat (10) @(negedge eth_clk);
        check("stall_abort_cnt", 64'(o_abort_cnt), 64'd1);
        check("stall_grant_released", 64'(o_grant), 64'd0);
        check("stall_drained", 64'(src_q[2].size()), 64'd0);

        // MAC backpressure toggling during an 8-beat packet.
        tick();
        push_src(1, 0, 8, 0);
        push_exp(1, 0, 8, 8, -1);
        for (int i = 0; i < 24; i++) begin
            tick();
            mac_tready = ~mac_tready;
        end
        mac_tready = 1'b1;
        wait_drain("toggle", 50);
        check("toggle_abort_cnt", 64'(o_abort_cnt), 64'd1);

        // Link not ready: no grants until i_eth_rdy rises.
        tick();
        push_src(3, 4, 1, 0);
        push_exp(3, 4, 1, 1, -1);
        wait_drain("p3_setup", 20);
        tick();
        eth_rdy = 1'b0;
        tick();
        push_src(0, 5, 1, 0);
        push_src(3, 5, 1, 0);
        push_exp(0, 5, 1, 1, -1);
        push_exp(3, 5, 1, 1, -1);
        for (int i = 0; i < 6; i++) begin
            @(negedge eth_clk);
            check("rdy_low_grant", 64'(o_grant), 64'd0);
            check("rdy_low_tready", 64'(o_axis_tready), 64'd0);
        end
        tick();
        eth_rdy = 1'b1;
        @(negedge eth_clk);
        @(negedge eth_clk);
        check("rdy_rise_grant", 64'(o_grant), 64'd1);
        wait_drain("rdy", 20);

        // Asynchronous reset during beat 2 of a 5-beat packet.
        tick();
        c0 = cyc;
        push_src(2, 6, 5, 0);
        push_exp(2, 6, 5, 1, c0 + 2);
        repeat (3) @(posedge eth_clk);
        #3;
        check("beat2_presented", 64'(o_eth_axis_tx_tvalid), 64'd1);
        eth_rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({o_eth_axis_tx_tvalid, o_eth_axis_tx_tlast, o_eth_axis_tx_tuser, |o_eth_axis_tx_tdata,
                   |o_eth_axis_tx_tkeep, o_axis_tready, o_grant, o_abort_cnt}), 64'd0);
        check("reset_beat1_delivered", 64'(exp_q.size()), 64'd0);
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        repeat (2) @(posedge eth_clk);
        #2;
        eth_rst_n = 1'b1;
        c0 = cyc;
        push_src(0, 7, 1, 0);
        push_src(1, 7, 1, 0);
        push_src(2, 7, 1, 0);
        push_exp(0, 7, 1, 1, c0 + 2);
        push_exp(1, 7, 1, 1, c0 + 4);
        push_exp(2, 7, 1, 1, c0 + 6);
        @(negedge eth_clk);
        @(negedge eth_clk);
        @(negedge eth_clk);
        check("post_reset_grant", 64'(o_grant), 64'd1);
        wait_drain("post_reset", 20);

        // Ports 0 and 1 both keep offering 2-beat packets.
        tick();
        push_src(0, 8, 2, 0);
        push_src(0, 9, 2, 0);
        push_src(1, 8, 2, 0);
        push_src(1, 9, 2, 0);
        for (int i = 0; i < 4; i++) push_exp(ord6p[i], ord6k[i], 2, 2, -1);
        @(negedge eth_clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge eth_clk);
            expg = (c % 3 == 0) ? '0 : NP'(1) << ord6p[c / 3];
            check("pair_grant_trace", 64'(o_grant), 64'(expg));
        end
        wait_drain("pair", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
